// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing with redirect/stall handling, a single
// IF/ID pipeline register, a sticky misalignment flag and a halt-word detector.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'h0000_0FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic        halted,
  output logic [31:0] fetch_count
);

  // state | meaning
  // BOOT  | one idle cycle after reset release, pc parked at RESET_PC
  // RUN   | fetching; redirects, stalls and sequential advance
  // HALT  | halt word latched; everything frozen until reset
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic        redirect;
  logic [31:0] target;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          pc_d    = target & ADDR_MASK & ~32'h3;
          valid_d = 1'b0;
          if (target[1:0] != 2'b00) mis_d = 1'b1;
        end else if (!stall) begin
          ins_d   = instruction;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          // The halt word's own address stays on pc while halted.
          if (instruction == HALT_WORD) state_d = HALT;
          else                          pc_d    = (pc_q + 32'd4) & ADDR_MASK;
        end
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc                = pc_q;
  assign if_id_instruction = ins_q;
  assign if_id_pc          = ipc_q;
  assign if_id_valid       = valid_q;
  assign misaligned        = mis_q;
  assign halted            = (state_q == HALT);
  assign fetch_count       = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model updated on each clock edge
// is compared against every output on each falling edge, plus literal checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        misaligned;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [1024];

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .instruction       (instruction),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump              (jump),
    .jump_target       (jump_target),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid),
    .misaligned        (misaligned),
    .halted            (halted),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  assign instruction = mem[pc[11:2]];

  // Reference model: started/halt flags instead of a state machine.
  bit          m_started = 0;
  bit          m_halt    = 0;
  logic [31:0] m_pc      = 0;
  logic [31:0] m_ins     = 0;
  logic [31:0] m_ipc     = 0;
  bit          m_valid   = 0;
  bit          m_mis     = 0;
  logic [31:0] m_cnt     = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] t;
    if (!rst_n) begin
      m_started = 0; m_halt = 0; m_pc = 0; m_ins = 0; m_ipc = 0;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (jump || branch_taken) begin
      t = jump ? jump_target : branch_target;
      if (t % 4 != 0) m_mis = 1;
      m_pc    = (t % 4096) / 4 * 4;
      m_valid = 0;
    end else if (!stall) begin
      m_ins   = mem[m_pc / 4];
      m_ipc   = m_pc;
      m_valid = 1;
      m_cnt   = m_cnt + 1;
      if (m_ins == 32'hFFFF_FFFF) m_halt = 1;
      else                        m_pc   = (m_pc + 4) % 4096;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_pc",    pc, m_pc);
    chk("m_ins",   if_id_instruction, m_ins);
    chk("m_ipc",   if_id_pc, m_ipc);
    chk("m_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("m_mis",   {31'b0, misaligned}, {31'b0, m_mis});
    chk("m_halt",  {31'b0, halted}, {31'b0, m_halt});
    chk("m_cnt",   fetch_count, m_cnt);
  end

  task automatic step(input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    stall = s; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    @(posedge clk);
    @(negedge clk);
    stall = 0; branch_taken = 0; jump = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_ins"},   if_id_instruction, 32'h0);
    chk({tag, "_ipc"},   if_id_pc, 32'h0);
    chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    chk({tag, "_mis"},   {31'b0, misaligned}, 32'h0);
    chk({tag, "_halt"},  {31'b0, halted}, 32'h0);
    chk({tag, "_cnt"},   fetch_count, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h4444_4444;

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    idle();
    chk("boot_pc", pc, 32'h0);
    chk("boot_valid", {31'b0, if_id_valid}, 32'h0);
    idle();
    chk("f0_ins", if_id_instruction, 32'h1111_1111);
    chk("f0_ipc", if_id_pc, 32'h0);
    chk("f0_valid", {31'b0, if_id_valid}, 32'h1);
    idle();
    chk("f1_ins", if_id_instruction, 32'h2222_2222);
    chk("f1_ipc", if_id_pc, 32'h4);
    chk("f1_pc", pc, 32'h8);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("stall_pc", pc, 32'h8);
    chk("stall_ins", if_id_instruction, 32'h2222_2222);
    chk("stall_cnt", fetch_count, 32'd2);
    idle();
    chk("f2_ins", if_id_instruction, 32'h3333_3333);
    chk("f2_ipc", if_id_pc, 32'h8);
    chk("f2_cnt", fetch_count, 32'd3);

    step(1, 1, 32'h80, 1, 32'h40);
    chk("prio_pc", pc, 32'h40);
    chk("prio_valid", {31'b0, if_id_valid}, 32'h0);
    chk("prio_ins_hold", if_id_instruction, 32'h3333_3333);
    step(0, 1, 32'h82, 0, 0);
    chk("mis_pc", pc, 32'h80);
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    idle();
    chk("f80_ins", if_id_instruction, 32'hA000_0020);
    chk("f80_cnt", fetch_count, 32'd4);

    step(0, 0, 0, 1, 32'hFFC);
    idle();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_ipc", if_id_pc, 32'hFFC);
    step(0, 0, 0, 1, 32'h1004);
    chk("jwrap_pc", pc, 32'h4);

    // reset dropped during a stall, between edges
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_stall");
    stall = 1'b0;
    mem[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;

    idle();
    idle();
    step(0, 0, 0, 1, 32'h0);
    repeat (4) idle();
    chk("hw_valid", {31'b0, if_id_valid}, 32'h1);
    chk("hw_ipc", if_id_pc, 32'hC);
    chk("hw_ins", if_id_instruction, 32'hFFFF_FFFF);
    chk("hw_pc", pc, 32'hC);
    chk("hw_halted", {31'b0, halted}, 32'h1);
    chk("hw_cnt", fetch_count, 32'd5);
    step(0, 0, 0, 1, 32'h0);
    chk("halt_pc", pc, 32'hC);
    chk("halt_valid", {31'b0, if_id_valid}, 32'h0);
    chk("halt_cnt", fetch_count, 32'd5);
    step(1, 1, 32'h40, 0, 0);
    chk("halt_pc2", pc, 32'hC);

    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_halt");
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] are 0.
REQ-002 Parameter ADDR_MASK, default 32'h0000_0FFF: PC address-space mask, matching a 4096-byte instruction store.
REQ-003 The block SHALL use one clock, clk, with an asynchronous, active-low reset, rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pc  output  32  byte address presented to the instruction store; big-endian word at pc..pc+3.
REQ-007 instruction  input  32  word returned combinationally for the current pc.
REQ-008 stall  input  1  hold PC and IF/ID register.
REQ-009 branch_taken  input  1  redirect to branch_target.
REQ-010 branch_target  input  32  branch destination byte address.
REQ-011 jump  input  1  redirect to jump_target.
REQ-012 jump_target  input  32  jump destination byte address.
REQ-013 if_id_instruction  output  32  registered fetched word.
REQ-014 if_id_pc  output  32  PC of if_id_instruction.
REQ-015 if_id_valid  output  1  if_id_instruction is a real instruction, not a bubble.
REQ-016 misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0.
REQ-017 halted  output  1  fetch stopped on a halt word.
REQ-018 fetch_count  output  32  number of instructions delivered with if_id_valid=1.

Function
REQ-019 The block SHALL use 3 states: BOOT, RUN, HALT.
- BOOT->RUN on the first clk edge after rst_n rises.
- RUN->HALT when a word equal to 32'hFFFF_FFFF is latched into IF/ID.
- HALT exits only through reset.
REQ-020 In BOOT the block SHALL hold pc at RESET_PC and drive if_id_valid=0.
REQ-021 In RUN the next PC SHALL be selected in priority order jump > branch_taken > stall > sequential, where sequential = (pc+4) & ADDR_MASK.
- 32'h0000_0FFC therefore wraps to 0.
REQ-022 Redirect targets SHALL be applied as (target & ADDR_MASK) & ~32'h3.
- Any target with bits [1:0] != 0 sets misaligned=1 until reset.
REQ-023 A RUN edge with no redirect and no stall SHALL load if_id_instruction<=instruction and if_id_pc<=pc, set if_id_valid<=1, and increment fetch_count.
REQ-024 Latency SHALL be 1 cycle: the word at pc appears on if_id_instruction on the edge after pc is presented.
REQ-025 A RUN edge with stall=1 and no redirect SHALL hold pc, if_id_instruction, if_id_pc, if_id_valid and fetch_count unchanged.
REQ-026 A RUN edge with jump=1 or branch_taken=1 SHALL load the redirected PC and set if_id_valid<=0 (flush), regardless of stall.
- if_id_instruction and if_id_pc SHALL hold their previous values.
REQ-027 When jump and branch_taken are asserted together, jump_target SHALL be used.
REQ-028 On the edge that latches the halt word, the block SHALL:
- set if_id_valid=1;
- increment fetch_count;
- hold pc at the halt word's address;
- go to HALT with halted=1.
REQ-029 In HALT, pc, fetch_count and if_id_instruction SHALL freeze; if_id_valid=0 from the next edge; stall, jump and branch_taken are ignored.
REQ-030 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-031 While rst_n=0, asynchronously and independent of clk, the block SHALL set:
- state=BOOT, pc=RESET_PC;
- if_id_instruction=0, if_id_pc=0, if_id_valid=0;
- misaligned=0, halted=0, fetch_count=0.
REQ-032 A reset asserted mid-operation, including in HALT or during stall, SHALL abandon any in-flight fetch; no partial update is permitted on the edge coinciding with rst_n falling.

Verification
REQ-033 Sequential fetch: memory words 0x11111111, 0x22222222, 0x33333333 at bytes 0/4/8, release reset -> BOOT cycle with valid=0, then IF/ID = (0x11111111, pc 0), (0x22222222, pc 4), (0x33333333, pc 8) on consecutive edges; fetch_count=3.
REQ-034 Stall: assert stall for 2 cycles at pc=8 -> pc stays 8, IF/ID and fetch_count unchanged for 2 edges, then resumes at 8.
REQ-035 Redirect priority: jump=1 to 0x40 and branch_taken=1 to 0x80 in the same cycle, with stall=1 -> pc=0x40, if_id_valid=0 on that edge; branch_target 0x82 alone -> pc=0x80, misaligned=1.
REQ-036 Wrap: pc=0xFFC sequential -> next pc=0x000; jump_target 0x1004 -> pc=0x004.
REQ-037 Halt: 0xFFFFFFFF at byte 12 -> if_id_valid=1 with if_id_pc=12, then halted=1, pc frozen at 12, valid=0; a jump to 0 is ignored.
REQ-038 Async reset: drop rst_n between clock edges while in HALT with fetch_count=5 -> all outputs reach reset values immediately, without waiting for a clock edge.
